// File: rtl/sleep_pkg.sv
// Shared definitions for the sleep-style timing callees: the call-state
// encoding, the prescaler width helper and the default clock rate.
package sleep_pkg;

    // 100 MHz clock: one millisecond is 100000 cycles.
    localparam int unsigned DEFAULT_CYCLES_PER_MS = 100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sleepState_e;

    // Smallest width that can hold CYCLES_PER_MS-1, never less than one bit.
    function automatic int unsigned prescalerWidth(input int unsigned cyclesPerMs);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((32'd1 << w) < cyclesPerMs)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Loadable down-counter that divides the clock into millisecond periods.
// A load restarts the period at CYCLES_PER_MS-1; while enabled it counts
// down and parks at zero, where terminal marks the last cycle of the period.
module ms_prescaler
    import sleep_pkg::*;
#(
    parameter int unsigned CYCLES_PER_MS = DEFAULT_CYCLES_PER_MS,
    localparam int unsigned PW = prescalerWidth(CYCLES_PER_MS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          enable_i,
    output logic          terminal_o,
    output logic [PW-1:0] count_o
);

    localparam logic [PW-1:0] RELOAD = PW'(CYCLES_PER_MS - 1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    // Next count: a load wins over counting, and the counter holds at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = RELOAD;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - PW'(1);
        end
    end

    // Count register, cleared asynchronously so an abandoned sleep leaves no residue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_o = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/sleep_ms_timer.sv
// Callee for the HLS `sleep` call: latches a millisecond count on start,
// counts it down on the 1 ms prescaler, pulses valid for one cycle and
// returns to idle. Port names follow the caller's call interface.
module sleep_ms_timer
    import sleep_pkg::*;
#(
    parameter int unsigned CYCLES_PER_MS = DEFAULT_CYCLES_PER_MS,
    parameter int unsigned MS_WIDTH      = 32
) (
    input  logic                __clk,
    input  logic                __reset,
    input  logic [MS_WIDTH-1:0] ms,
    input  logic                __start,
    output logic                __idle,
    output logic                __valid,
    output logic [MS_WIDTH-1:0] remaining
);

    localparam int unsigned PW = prescalerWidth(CYCLES_PER_MS);

    sleepState_e         state_q;
    sleepState_e         state_d;
    logic [MS_WIDTH-1:0] remaining_q;
    logic [MS_WIDTH-1:0] remaining_d;

    logic                presLoad;
    logic                presEnable;
    logic                presTerminal;
    logic [PW-1:0]       presCount;
    logic                msTick;

    ms_prescaler #(
        .CYCLES_PER_MS (CYCLES_PER_MS)
    ) u_prescaler (
        .clk_i      (__clk),
        .rst_i      (__reset),
        .load_i     (presLoad),
        .enable_i   (presEnable),
        .terminal_o (presTerminal),
        .count_o    (presCount)
    );

    assign presEnable = (state_q == ST_RUN);

    // A millisecond boundary is the last prescaler cycle of a period; the
    // flag and the zero count describe the same event and must agree.
    assign msTick = presTerminal && (presCount == '0);

    // Call sequencing: accept in IDLE, count whole milliseconds in RUN,
    // and spend exactly one cycle in DONE before accepting again.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        presLoad    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (__start) begin
                    if (ms == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_RUN;
                        remaining_d = ms;
                        presLoad    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (msTick) begin
                    if (remaining_q == MS_WIDTH'(1)) begin
                        state_d     = ST_DONE;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - MS_WIDTH'(1);
                        presLoad    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and remaining-count registers; reset abandons any sleep in flight.
    always_ff @(posedge __clk or posedge __reset) begin
        if (__reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    assign __idle    = (state_q == ST_IDLE);
    assign __valid   = (state_q == ST_DONE);
    assign remaining = remaining_q;

endmodule

// File: tb/tb_sleep_ms_timer.sv
// Bench for sleep_ms_timer: two instances (4 and 1 cycles per ms) driven by
// directed and random calls. A reference model predicts idle/remaining from
// the call's start cycle and duration, and a scoreboard queue holds the
// cycle in which each accepted call must raise valid.
module tb_sleep_ms_timer;

    localparam int unsigned CPM_A = 4;
    localparam int unsigned CPM_B = 1;
    localparam int unsigned MSW   = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           startA = 1'b0;
    logic           startB = 1'b0;
    logic [MSW-1:0] msA = '0;
    logic [MSW-1:0] msB = '0;
    logic           idleA, validA, idleB, validB;
    logic [MSW-1:0] remA, remB;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    bit     active   [2];
    longint startCyc [2];
    longint msModel  [2];
    longint cpm      [2];
    longint expQ0[$];
    longint expQ1[$];

    sleep_ms_timer #(.CYCLES_PER_MS(CPM_A), .MS_WIDTH(MSW)) dutA (
        .__clk     (clock),
        .__reset   (reset),
        .ms        (msA),
        .__start   (startA),
        .__idle    (idleA),
        .__valid   (validA),
        .remaining (remA)
    );

    sleep_ms_timer #(.CYCLES_PER_MS(CPM_B), .MS_WIDTH(MSW)) dutB (
        .__clk     (clock),
        .__reset   (reset),
        .ms        (msB),
        .__start   (startB),
        .__idle    (idleB),
        .__valid   (validB),
        .remaining (remB)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Cycle index: cycle N is the interval that starts at the N-th rising edge.
    always @(posedge clock) cyc = cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit qEmpty(input int d);
        return (d == 0) ? (expQ0.size() == 0) : (expQ1.size() == 0);
    endfunction

    function automatic longint qFront(input int d);
        return (d == 0) ? expQ0[0] : expQ1[0];
    endfunction

    function automatic longint qPop(input int d);
        if (d == 0) return expQ0.pop_front();
        return expQ1.pop_front();
    endfunction

    function automatic void qPush(input int d, input longint v);
        if (d == 0) expQ0.push_back(v);
        else        expQ1.push_back(v);
    endfunction

    function automatic void qClear(input int d);
        if (d == 0) expQ0.delete();
        else        expQ1.delete();
    endfunction

    // One model/monitor step for instance d, evaluated mid-cycle.
    task automatic modelStep(input int d, input logic idle, input logic valid,
                             input logic [MSW-1:0] rem, input logic st,
                             input logic [MSW-1:0] m);
        string  tag;
        longint doneCyc;
        longint expIdle;
        longint expRem;
        tag = (d == 0) ? "A" : "B";
        if (reset) begin
            active[d] = 1'b0;
            qClear(d);
            checkOutput({tag, ".idle_in_reset"}, longint'(idle), 1);
            checkOutput({tag, ".valid_in_reset"}, longint'(valid), 0);
            checkOutput({tag, ".remaining_in_reset"}, longint'(rem), 0);
            return;
        end
        if (active[d] && (cyc > startCyc[d] + msModel[d] * cpm[d] + 1))
            active[d] = 1'b0;
        if (!active[d]) begin
            expIdle = 1;
            expRem  = 0;
        end else begin
            doneCyc = startCyc[d] + msModel[d] * cpm[d] + 1;
            expIdle = 0;
            if (cyc < doneCyc) expRem = msModel[d] - (cyc - startCyc[d] - 1) / cpm[d];
            else               expRem = 0;
        end
        checkOutput({tag, ".idle"}, longint'(idle), expIdle);
        checkOutput({tag, ".remaining"}, longint'(rem), expRem);
        if (valid) begin
            if (qEmpty(d)) checkOutput({tag, ".valid_unexpected"}, 1, 0);
            else           checkOutput({tag, ".valid_cycle"}, cyc, qPop(d));
        end else if (!qEmpty(d) && (qFront(d) <= cyc)) begin
            checkOutput({tag, ".valid_missing"}, 0, 1);
            void'(qPop(d));
        end
        if (!active[d] && st) begin
            active[d]   = 1'b1;
            startCyc[d] = cyc;
            msModel[d]  = longint'(m);
            qPush(d, cyc + longint'(m) * cpm[d] + 1);
        end
    endtask

    // Monitor: compare both instances against the model on every falling edge.
    always @(negedge clock) begin
        modelStep(0, idleA, validA, remA, startA, msA);
        modelStep(1, idleB, validB, remB, startB, msB);
    end

    // Raise start with the given duration for holdCycles cycles.
    task automatic applyStimulus(input int d, input logic [MSW-1:0] m, input int holdCycles);
        @(posedge clock);
        #1;
        if (d == 0) begin startA = 1'b1; msA = m; end
        else        begin startB = 1'b1; msB = m; end
        repeat (holdCycles) @(posedge clock);
        #1;
        if (d == 0) begin startA = 1'b0; msA = MSW'($urandom); end
        else        begin startB = 1'b0; msB = MSW'($urandom); end
    endtask

    task automatic waitIdle(input int d, input int budget);
        int n;
        n = 0;
        while (active[d] && (n < budget)) begin
            @(posedge clock);
            n++;
        end
        if (active[d]) checkOutput("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        cpm[0] = CPM_A;
        cpm[1] = CPM_B;
        active[0] = 1'b0;
        active[1] = 1'b0;
        #1 reset = 1'b1;
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);

        applyStimulus(0, 8'd3, 1);
        waitIdle(0, 100);
        applyStimulus(0, 8'd0, 1);
        waitIdle(0, 100);

        applyStimulus(0, 8'd2, 1);
        repeat (2) @(posedge clock);
        #1 startA = 1'b1; msA = 8'd100;
        @(posedge clock);
        #1 startA = 1'b0;
        waitIdle(0, 100);

        applyStimulus(0, 8'd10, 1);
        repeat (6) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checkOutput("A.idle_async_reset", longint'(idleA), 1);
        checkOutput("A.valid_async_reset", longint'(validA), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        applyStimulus(0, 8'd1, 1);
        waitIdle(0, 100);

        applyStimulus(1, 8'd5, 1);
        waitIdle(1, 100);

        applyStimulus(0, 8'd1, 20);
        waitIdle(0, 100);

        applyStimulus(0, 8'd255, 1);
        waitIdle(0, 2000);
        applyStimulus(1, 8'd255, 1);
        waitIdle(1, 2000);

        for (int i = 0; i < 40; i++) begin
            int d;
            d = int'($urandom_range(0, 1));
            applyStimulus(d, MSW'($urandom_range(0, 12)), int'($urandom_range(1, 2)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clock);
                applyStimulus(d, MSW'($urandom_range(0, 200)), 1);
            end
            waitIdle(d, 1000);
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end

        waitIdle(0, 2000);
        waitIdle(1, 2000);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("A.scoreboard_drained", longint'(expQ0.size()), 0);
        checkOutput("B.scoreboard_drained", longint'(expQ1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
